// File: rtl/decode_issue_reg_pkg.sv
// Shared types for the decode->execute pipeline register.
// Holds word/register-index types, the transfer record and the captured payload.
package decode_issue_reg_pkg;

    localparam int WORD_W_P = 64;
    localparam int ADDR_W_P = 5;
    localparam int CTL_W_P  = 16;

    typedef logic [WORD_W_P-1:0] word_t;
    typedef logic [ADDR_W_P-1:0] creg_addr_t;

    typedef struct packed {
        creg_addr_t dst;
        word_t      data;
        logic       ismem;
    } tran_t;

    typedef struct packed {
        word_t               pc;
        word_t               rs1_val;
        word_t               rs2_val;
        creg_addr_t          dst;
        logic                ismem;
        logic [CTL_W_P-1:0]  ctl;
    } de_payload_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } de_state_e;

    // Result is not computed yet, so data is always zero; consumers bubble on a dst match.
    function automatic tran_t make_tran(input logic valid, input creg_addr_t dst,
                                        input logic ismem);
        tran_t t;
        t.dst   = valid ? dst : '0;
        t.data  = '0;
        t.ismem = valid & ismem;
        return t;
    endfunction

endpackage

// File: rtl/decode_issue_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Used for the optional pipeline performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/decode_issue_reg.sv
// Decode->execute pipeline register with bubble insertion, back-pressure and flush.
// Optional perf counters under PERF_CNT_EN; otherwise the counter ports read zero.
//
// state    | meaning
// ST_EMPTY | no valid occupant in execute (out_valid=0)
// ST_FULL  | execute holds a valid instruction (out_valid=1)
module decode_issue_reg
    import decode_issue_reg_pkg::*;
#(
    parameter int WORD_W = WORD_W_P,
    parameter int ADDR_W = ADDR_W_P,
    parameter int CTL_W  = CTL_W_P,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_rs1_val,
    input  logic [WORD_W-1:0] in_rs2_val,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_ismem,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic              bubble_a,
    input  logic              bubble_b,
    input  logic              stall_down,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_rs1_val,
    output logic [WORD_W-1:0] out_rs2_val,
    output logic [ADDR_W-1:0] out_dst,
    output logic              out_ismem,
    output logic [CTL_W-1:0]  out_ctl,
    output logic              stall_up,
    output tran_t             tran_d,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    de_state_e   r_state;
    de_state_e   w_state_nxt;
    de_payload_t r_payload;
    de_payload_t w_payload_nxt;
    de_payload_t w_in_payload;
    logic        w_hazard;

    assign w_hazard = in_valid & (bubble_a | bubble_b);
    // Flush kills the decode output, so holding upstream would only lose the redirect.
    assign stall_up = ~reset & ~flush & (stall_down | w_hazard);

    assign w_in_payload = '{
        pc:      in_pc,
        rs1_val: in_rs1_val,
        rs2_val: in_rs2_val,
        dst:     in_dst,
        ismem:   in_ismem,
        ctl:     in_ctl
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_payload <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_payload <= w_payload_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_payload_nxt = r_payload;
        if (flush) begin
            w_state_nxt   = ST_EMPTY;
            w_payload_nxt = '0;
        end else if (stall_down) begin
            // Hold; a coincident hazard is re-presented by decode next cycle.
            w_state_nxt   = r_state;
            w_payload_nxt = r_payload;
        end else if (w_hazard) begin
            w_state_nxt   = ST_EMPTY;
            w_payload_nxt = '0;
        end else if (in_valid) begin
            w_state_nxt   = ST_FULL;
            w_payload_nxt = w_in_payload;
        end else begin
            w_state_nxt   = ST_EMPTY;
            w_payload_nxt = '0;
        end
    end

    assign out_valid   = (r_state == ST_FULL);
    assign out_pc      = r_payload.pc;
    assign out_rs1_val = r_payload.rs1_val;
    assign out_rs2_val = r_payload.rs2_val;
    assign out_dst     = r_payload.dst;
    assign out_ismem   = r_payload.ismem;
    assign out_ctl     = r_payload.ctl;

    // Purely registered: breaks the operand-select <-> pipeline-register loop.
    assign tran_d = make_tran(out_valid, r_payload.dst, r_payload.ismem);

`ifdef PERF_CNT_EN
    logic w_bubble_en;
    logic w_flush_en;

    assign w_bubble_en = ~flush & ~stall_down & w_hazard;
    assign w_flush_en  = flush & (out_valid | in_valid);

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .i_clr   (reset),
        .i_en    (w_bubble_en),
        .o_count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .i_clr   (reset),
        .i_en    (w_flush_en),
        .o_count (flush_cnt)
    );
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_decode_issue_reg.sv
// Scoreboard bench for decode_issue_reg: directed vectors push expectations,
// a monitor pops one per clock edge and compares all outputs.
module tb_decode_issue_reg;
    import decode_issue_reg_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_rs1_val;
    logic [63:0] in_rs2_val;
    logic [4:0]  in_dst;
    logic        in_ismem;
    logic [15:0] in_ctl;
    logic        bubble_a;
    logic        bubble_b;
    logic        stall_down;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_rs1_val;
    logic [63:0] out_rs2_val;
    logic [4:0]  out_dst;
    logic        out_ismem;
    logic [15:0] out_ctl;
    logic        stall_up;
    tran_t       tran_d;
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;

    decode_issue_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_dst     (in_dst),
        .in_ismem   (in_ismem),
        .in_ctl     (in_ctl),
        .bubble_a   (bubble_a),
        .bubble_b   (bubble_b),
        .stall_down (stall_down),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val),
        .out_dst    (out_dst),
        .out_ismem  (out_ismem),
        .out_ctl    (out_ctl),
        .stall_up   (stall_up),
        .tran_d     (tran_d),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [63:0] pc;
        logic [4:0]  dst;
        logic        ism;
        logic        stall;
        logic [31:0] bc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Operand/control inputs are derived from the PC so the expected payload follows from it.
    function automatic logic [63:0] f_rs1(input logic [63:0] pc);
        return pc ^ 64'h5A5A_5A5A_0000_FFFF;
    endfunction
    function automatic logic [63:0] f_rs2(input logic [63:0] pc);
        return pc + 64'h1111;
    endfunction
    function automatic logic [15:0] f_ctl(input logic [63:0] pc);
        return pc[17:2] ^ 16'hA5C3;
    endfunction
    function automatic logic [31:0] cnt(input int v);
`ifdef PERF_CNT_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic chk(input string vn, input string fld, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", vn, fld, act, exp);
        end
    endtask

    // Monitor: stall_up sampled mid-cycle, registered outputs checked just after the edge.
    logic s_stall;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            s_stall = stall_up;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                chk(e.name, "out_valid",   64'(out_valid),   64'(e.v));
                chk(e.name, "out_pc",      out_pc,           e.pc);
                chk(e.name, "out_rs1_val", out_rs1_val,      e.v ? f_rs1(e.pc) : 64'h0);
                chk(e.name, "out_rs2_val", out_rs2_val,      e.v ? f_rs2(e.pc) : 64'h0);
                chk(e.name, "out_ctl",     64'(out_ctl),     e.v ? 64'(f_ctl(e.pc)) : 64'h0);
                chk(e.name, "out_dst",     64'(out_dst),     64'(e.dst));
                chk(e.name, "out_ismem",   64'(out_ismem),   64'(e.ism));
                chk(e.name, "tran_d.dst",  64'(tran_d.dst),  e.v ? 64'(e.dst) : 64'h0);
                chk(e.name, "tran_d.ismem",64'(tran_d.ismem),64'(e.v & e.ism));
                chk(e.name, "tran_d.data", tran_d.data,      64'h0);
                chk(e.name, "stall_up",    64'(s_stall),     64'(e.stall));
                chk(e.name, "bubble_cnt",  64'(bubble_cnt),  64'(e.bc));
                chk(e.name, "flush_cnt",   64'(flush_cnt),   64'(e.fc));
            end
        end
    end

    task automatic vec(input string name, input logic rst, input logic iv,
                       input logic [63:0] pc, input logic [4:0] dst, input logic ism,
                       input logic ba, input logic bb, input logic sd, input logic fl,
                       input logic ev, input logic [63:0] epc, input logic [4:0] edst,
                       input logic eism, input logic est, input int ebc, input int efc);
        exp_t e;
        @(posedge clk);
        #3;
        reset      = rst;
        in_valid   = iv;
        in_pc      = pc;
        in_rs1_val = f_rs1(pc);
        in_rs2_val = f_rs2(pc);
        in_ctl     = f_ctl(pc);
        in_dst     = dst;
        in_ismem   = ism;
        bubble_a   = ba;
        bubble_b   = bb;
        stall_down = sd;
        flush      = fl;
        e.name = name; e.v = ev; e.pc = epc; e.dst = edst; e.ism = eism;
        e.stall = est; e.bc = cnt(ebc); e.fc = cnt(efc);
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_pc = 0; in_rs1_val = 0; in_rs2_val = 0;
        in_dst = 0; in_ismem = 0; in_ctl = 0; bubble_a = 0; bubble_b = 0;
        stall_down = 0; flush = 0;

        //  name          rst iv pc            dst ism ba bb sd fl | ev epc           edst eism st bc fc
        vec("reset0",      1, 0, 64'h0,        0,  0,  0, 0, 0, 0,   0, 64'h0,        0,  0,  0, 0, 0);
        vec("reset1_sd",   1, 1, 64'h4,        3,  0,  1, 0, 1, 0,   0, 64'h0,        0,  0,  0, 0, 0);
        vec("first_load",  0, 1, 64'h8000_0000,5,  0,  0, 0, 0, 0,   1, 64'h8000_0000,5,  0,  0, 0, 0);
        vec("load_mem",    0, 1, 64'h8000_0004,7,  1,  0, 0, 0, 0,   1, 64'h8000_0004,7,  1,  0, 0, 0);
        vec("hazard_a",    0, 1, 64'h8000_0008,3,  0,  1, 0, 0, 0,   0, 64'h0,        0,  0,  1, 1, 0);
        vec("hazard_rel",  0, 1, 64'h8000_0008,3,  0,  0, 0, 0, 0,   1, 64'h8000_0008,3,  0,  0, 1, 0);
        vec("load_d9",     0, 1, 64'h8000_000C,9,  0,  0, 0, 0, 0,   1, 64'h8000_000C,9,  0,  0, 1, 0);
        vec("stall1",      0, 1, 64'h8000_0010,4,  0,  0, 0, 1, 0,   1, 64'h8000_000C,9,  0,  1, 1, 0);
        vec("stall2_hz",   0, 1, 64'h8000_0010,4,  0,  0, 1, 1, 0,   1, 64'h8000_000C,9,  0,  1, 1, 0);
        vec("stall3",      0, 1, 64'h8000_0010,4,  0,  0, 0, 1, 0,   1, 64'h8000_000C,9,  0,  1, 1, 0);
        vec("stall_rel",   0, 1, 64'h8000_0010,4,  0,  0, 0, 0, 0,   1, 64'h8000_0010,4,  0,  0, 1, 0);
        vec("flush_all",   0, 1, 64'h8000_0014,8,  1,  0, 1, 1, 1,   0, 64'h0,        0,  0,  0, 1, 1);
        vec("flush_idle",  0, 0, 64'h0,        0,  0,  0, 0, 0, 1,   0, 64'h0,        0,  0,  0, 1, 1);
        vec("dst_zero",    0, 1, 64'h8000_0018,0,  0,  0, 0, 0, 0,   1, 64'h8000_0018,0,  0,  0, 1, 1);
        vec("bub_novalid", 0, 0, 64'h0,        0,  0,  1, 0, 0, 0,   0, 64'h0,        0,  0,  0, 1, 1);
        vec("hz_hold1",    0, 1, 64'h8000_001C,2,  0,  1, 0, 0, 0,   0, 64'h0,        0,  0,  1, 2, 1);
        vec("hz_hold2",    0, 1, 64'h8000_001C,2,  0,  0, 1, 0, 0,   0, 64'h0,        0,  0,  1, 3, 1);
        vec("hz_done",     0, 1, 64'h8000_001C,2,  0,  0, 0, 0, 0,   1, 64'h8000_001C,2,  0,  0, 3, 1);
        vec("load_d6",     0, 1, 64'h8000_0020,6,  1,  0, 0, 0, 0,   1, 64'h8000_0020,6,  1,  0, 3, 1);
        vec("full_stall",  0, 1, 64'h8000_0024,1,  0,  0, 0, 1, 0,   1, 64'h8000_0020,6,  1,  1, 3, 1);
        vec("rst_in_stall",1, 1, 64'h8000_0024,1,  0,  1, 0, 1, 0,   0, 64'h0,        0,  0,  0, 0, 0);
        vec("post_reset",  0, 0, 64'h0,        0,  0,  0, 0, 0, 0,   0, 64'h0,        0,  0,  0, 0, 0);

        begin
            int budget;
            budget = 0;
            while (q.size() != 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (q.size() != 0) begin
                n_miss++;
                $display("FAIL drain actual=%0d pending required=0 pending", q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/decode_issue_reg.md
Name: decode_issue_reg

Overview:
- Decode→execute pipeline register for the 5-stage core. Captures decoded instruction and forwarded operand values from the decode stage.
- Converts the per-operand bypass-select bubble requests into an inserted NOP plus an upstream stall.
- Publishes the occupant's tran_t (dst, ismem, data) back to the operand-select instances as the "in-decode-output" transfer record.
- Handles execute-side back-pressure and branch-redirect flushes.

Parameters:
- WORD_W, 64, operand/PC width (matches word_t)
- ADDR_W, 5, register index width (matches creg_addr_t)
- CTL_W, 16, opaque decoded control-bundle width
- CNT_W, 32, perf counter width (only with PERF_CNT_EN)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode holds a valid instruction
- in_pc  in  WORD_W  instruction PC
- in_rs1_val  in  WORD_W  operand A after bypass select
- in_rs2_val  in  WORD_W  operand B after bypass select
- in_dst  in  ADDR_W  destination register (0 = none)
- in_ismem  in  1  instruction is a load
- in_ctl  in  CTL_W  decoded control bundle
- bubble_a  in  1  operand A select requests bubble
- bubble_b  in  1  operand B select requests bubble
- stall_down  in  1  execute cannot accept (multicycle op busy)
- flush  in  1  branch redirect; kill decode output
- out_valid  out  1  execute-stage occupant valid
- out_pc, out_rs1_val, out_rs2_val  out  WORD_W each  registered payload
- out_dst  out  ADDR_W  registered destination
- out_ismem  out  1  registered load flag
- out_ctl  out  CTL_W  registered control
- stall_up  out  1  freeze fetch/decode this cycle
- tran_d  out  tran_t  {dst, data, ismem} of occupant, fed to operand selects
- bubble_cnt, flush_cnt  out  CNT_W each  perf counters

Behaviour:
- Reset: out_valid=0; all payload outputs 0; tran_d = all zero; counters 0; stall_up=0 while reset is asserted.
- hazard = in_valid & (bubble_a | bubble_b). Combinational.
- stall_up = ~flush & (stall_down | hazard). Combinational; flush never stalls upstream.
- State is EMPTY (out_valid=0) or FULL (out_valid=1). Update priority at the rising edge:
  1. reset → EMPTY, payload 0.
  2. flush → EMPTY, payload 0. Wins over stall_down, hazard and in_valid, including when all are asserted together.
  3. stall_down → hold every register unchanged. A hazard in the same cycle is ignored; decode re-presents the instruction next cycle.
  4. hazard → load bubble: out_valid=0, out_dst=0, out_ismem=0. Other payload fields are don't-care; implementation zeroes them.
  5. in_valid → load payload, out_valid=1.
  6. otherwise → EMPTY.
- Latency: 1 cycle from capture to out_*.
- tran_d:
  - dst = out_valid ? out_dst : 0
  - ismem = out_valid & out_ismem
  - data = 0, because the result is not yet computed. The select stage must bubble on a dst match; dst 0 never matches since selects skip ra==0.
- No combinational path exists from bubble_* to tran_d; tran_d is purely registered. This breaks the select↔register loop.
- A hazard held for N consecutive cycles inserts N bubbles. There is no upper bound; it resolves when the producer advances.
- Reset asserted mid-stall clears everything in one cycle.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined:
  - bubble_cnt increments on every edge where rule 4 applies.
  - flush_cnt increments on every edge where rule 2 applies with out_valid or in_valid high.
  - Both saturate at all-ones and clear on reset.
- When undefined: the ports still exist and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package pipes: add de_payload_t struct {pc, rs1_val, rs2_val, dst, ismem, ctl}. Reuse the existing tran_t.
- Package common: word_t and creg_addr_t, already present.
- One sub-module: sat_counter (CNT_W-wide, enable plus synchronous clear), instantiated twice under PERF_CNT_EN.

Test Plan:
- Reset for 2 cycles, then in_valid=1, pc=0x8000_0000, dst=5 → next cycle out_valid=1, out_pc=0x8000_0000, tran_d.dst=5, stall_up=0.
- Load (ismem=1, dst=7) captured, then next instruction with bubble_a=1 → stall_up=1; next edge out_valid=0, tran_d.dst=0; bubble_cnt=1.
- stall_down=1 for 3 cycles with occupant dst=9 → outputs unchanged for 3 cycles, stall_up=1 throughout; released on cycle 4 and the new instruction loads.
- flush=1 together with stall_down=1 and bubble_b=1 → next edge out_valid=0, stall_up=0 during the flush cycle, flush_cnt=1.
- in_valid=1, dst=0 → out_valid=1 but tran_d.dst=0; a select with ra=0 produces no bubble.
- Reset pulse while FULL and stalled → next cycle out_valid=0, counters 0, tran_d zero.
